// File: rtl/intc_prio_pkg.sv
// intc_prio_pkg: shared types and constants for the priority interrupt controller.
// Source register layout and the masks applied on bus writes and reads.
package intc_prio_pkg;

    typedef struct packed {
        logic       mode;
        logic [2:0] rsv1;
        logic [3:0] pri;
        logic       rsv0;
        logic [6:0] vec;
    } src_t;

    localparam logic [15:0] SRC_WMASK = 16'h8F7F;
    localparam logic [15:0] SRC_RMASK = 16'h8F7F;
    localparam logic [15:0] SRC_INIT  = 16'h0000;

    // Window always spans 32 halfword slots, whatever N_SRC is.
    localparam logic [31:0] WIN_BYTES = 32'd64;

endpackage

// File: rtl/intc_prio_if.sv
// intc_prio_if: IBUS register port of the priority interrupt controller.
// master drives the access, slave answers it.
interface intc_prio_if;
    logic [31:0] IBUS_A;
    logic [31:0] IBUS_DI;
    logic [3:0]  IBUS_BA;
    logic        IBUS_WE;
    logic        IBUS_REQ;
    logic [31:0] IBUS_DO;
    logic        IBUS_BUSY;
    logic        IBUS_ACT;

    modport master (
        output IBUS_A, IBUS_DI, IBUS_BA, IBUS_WE, IBUS_REQ,
        input  IBUS_DO, IBUS_BUSY, IBUS_ACT
    );

    modport slave (
        input  IBUS_A, IBUS_DI, IBUS_BA, IBUS_WE, IBUS_REQ,
        output IBUS_DO, IBUS_BUSY, IBUS_ACT
    );
endinterface

// File: rtl/intc_prio_arb.sv
// intc_prio_arb: combinational (level, index) tournament over M candidates.
// Highest level wins; equal levels resolve to the lower index.
module intc_prio_arb #(
    parameter int M  = 17,
    parameter int IW = $clog2(M)
) (
    input  logic [M-1:0]      cand_v,
    input  logic [M-1:0][4:0] cand_l,
    output logic              win_v,
    output logic [IW-1:0]     win_i
);

    localparam int P = 1 << IW;

    logic          nv [IW+1][P];
    logic [4:0]    nl [IW+1][P];
    logic [IW-1:0] ni [IW+1][P];

    always_comb begin
        for (int s = 0; s <= IW; s++) begin
            for (int k = 0; k < P; k++) begin
                nv[s][k] = 1'b0;
                nl[s][k] = '0;
                ni[s][k] = '0;
            end
        end
        for (int k = 0; k < M; k++) begin
            nv[0][k] = cand_v[k];
            nl[0][k] = cand_l[k];
            ni[0][k] = IW'(k);
        end
        for (int s = 0; s < IW; s++) begin
            for (int k = 0; k < (P >> (s + 1)); k++) begin
                if (nv[s][2*k+1] &&
                    (!nv[s][2*k] || nl[s][2*k+1] > nl[s][2*k])) begin
                    nv[s+1][k] = nv[s][2*k+1];
                    nl[s+1][k] = nl[s][2*k+1];
                    ni[s+1][k] = ni[s][2*k+1];
                end else begin
                    nv[s+1][k] = nv[s][2*k];
                    nl[s+1][k] = nl[s][2*k];
                    ni[s+1][k] = ni[s][2*k];
                end
            end
        end
    end

    assign win_v = nv[IW][0];
    assign win_i = ni[IW][0];

endmodule

// File: rtl/intc_prio.sv
// intc_prio: N-source priority interrupt controller with IBUS-mapped source registers.
// Define INTC_PRIO_NMI_EN to include the falling-edge NMI at level 16.
module intc_prio
    import intc_prio_pkg::*;
#(
    parameter int          N_SRC     = 16,
    parameter logic [31:0] BASE_ADDR = 32'hFFFFFE80,
    parameter logic [7:0]  NMI_VEC   = 8'd11
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             CE_R,
    input  logic             CE_F,
    input  logic             RES_N,
    input  logic             NMI_N,
    input  logic [N_SRC-1:0] IRQ,
    input  logic [3:0]       INT_MASK,
    input  logic             INT_ACK,
    output logic             INT_REQ,
    output logic [3:0]       INT_LVL,
    output logic [7:0]       INT_VEC,
    intc_prio_if.slave       ibus
);

    localparam int M  = N_SRC + 1;
    localparam int IW = $clog2(M);

    src_t             src [N_SRC];
    logic [N_SRC-1:0] pend;
    logic [N_SRC-1:0] irq_q;
    logic             nmi_pend;
    logic [IW-1:0]    sel;

    logic [31:0]      off;
    logic             act;
    logic [4:0]       idx;
    logic             wr;
    logic [15:0]      wdat;
    logic [1:0]       wbe;
    logic [15:0]      rd_word;
    logic [31:0]      do_q;
    logic             ack_hit;
    logic             unused_off;

    logic [M-1:0]      cand_v;
    logic [M-1:0][4:0] cand_l;
    logic              win_v;
    logic [IW-1:0]     win_i;
    logic [3:0]        win_lvl;
    logic [7:0]        win_vec;

    assign off        = ibus.IBUS_A - BASE_ADDR;
    assign act        = off < WIN_BYTES;
    assign idx        = off[5:1];
    assign unused_off = off[0];
    assign wr         = ibus.IBUS_REQ & ibus.IBUS_WE & act & RES_N;
    assign wdat       = ibus.IBUS_A[1] ? ibus.IBUS_DI[15:0]
                                       : ibus.IBUS_DI[31:16];
    assign wbe        = ibus.IBUS_A[1] ? ibus.IBUS_BA[1:0]
                                       : ibus.IBUS_BA[3:2];
    assign ack_hit    = INT_ACK & INT_REQ;

    assign ibus.IBUS_ACT  = act;
    assign ibus.IBUS_BUSY = 1'b0;
    assign ibus.IBUS_DO   = do_q;

    always_comb begin
        cand_v  = '0;
        cand_l  = '0;
        rd_word = '0;
        for (int i = 0; i < N_SRC; i++) begin
            cand_v[i] = pend[i] && (src[i].pri > INT_MASK);
            cand_l[i] = {1'b0, src[i].pri};
            if (idx == 5'(i))
                rd_word = src[i] & SRC_RMASK;
        end
        cand_v[N_SRC] = nmi_pend;
        cand_l[N_SRC] = 5'd16;
    end

    intc_prio_arb #(.M(M), .IW(IW)) u_arb (
        .cand_v (cand_v),
        .cand_l (cand_l),
        .win_v  (win_v),
        .win_i  (win_i)
    );

    always_comb begin
        win_lvl = 4'hF;
        win_vec = NMI_VEC;
        for (int i = 0; i < N_SRC; i++) begin
            if (win_i == IW'(i)) begin
                win_lvl = src[i].pri;
                win_vec = {1'b0, src[i].vec};
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < N_SRC; i++)
                src[i] <= SRC_INIT;
            pend  <= '0;
            irq_q <= '0;
        end else if (CE_R) begin
            irq_q <= IRQ;
            for (int i = 0; i < N_SRC; i++) begin
                if (!RES_N) begin
                    src[i]  <= SRC_INIT;
                    pend[i] <= 1'b0;
                end else begin
                    // Edge set beats an ack clear in the same cycle.
                    if (!src[i].mode)
                        pend[i] <= IRQ[i];
                    else if (IRQ[i] && !irq_q[i])
                        pend[i] <= 1'b1;
                    else if (ack_hit && sel == IW'(i))
                        pend[i] <= 1'b0;
                    if (wr && idx == 5'(i)) begin
                        if (wbe[1]) begin
                            src[i][15:8] <= wdat[15:8] & SRC_WMASK[15:8];
                            pend[i]      <= 1'b0;
                        end
                        if (wbe[0])
                            src[i][7:0] <= wdat[7:0] & SRC_WMASK[7:0];
                    end
                end
            end
        end
    end

    // Ack holds SEL and the outputs; the next winner lands one CE_R later.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            INT_REQ <= 1'b0;
            INT_LVL <= 4'hF;
            INT_VEC <= '0;
            sel     <= '0;
        end else if (CE_R) begin
            if (ack_hit) begin
                INT_REQ <= 1'b0;
            end else begin
                INT_REQ <= win_v;
                if (win_v) begin
                    sel     <= win_i;
                    INT_LVL <= win_lvl;
                    INT_VEC <= win_vec;
                end
            end
        end
    end

`ifdef INTC_PRIO_NMI_EN
    logic nmi_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            nmi_q    <= 1'b1;
            nmi_pend <= 1'b0;
        end else if (CE_R) begin
            nmi_q <= NMI_N;
            if (!RES_N)
                nmi_pend <= 1'b0;
            else if (nmi_q && !NMI_N)
                nmi_pend <= 1'b1;
            else if (ack_hit && sel == IW'(N_SRC))
                nmi_pend <= 1'b0;
        end
    end
`else
    logic unused_nmi;

    assign unused_nmi = NMI_N;
    assign nmi_pend   = 1'b0;
`endif

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)
            do_q <= '0;
        else if (CE_F && ibus.IBUS_REQ && !ibus.IBUS_WE && act)
            do_q <= {2{rd_word}};
    end

endmodule

// File: tb/tb_intc_prio.sv
// tb_intc_prio: randomized and directed checks of intc_prio against a
// behavioural model; a monitor compares outputs popped from expectation queues.
module tb_intc_prio;

    localparam int          N    = 16;
    localparam logic [31:0] BASE = 32'hFFFFFE80;

    logic         CLK = 1'b0;
    logic         RST_N = 1'b0;
    logic         CE_R = 1'b0;
    logic         CE_F = 1'b0;
    logic         RES_N = 1'b1;
    logic         NMI_N = 1'b1;
    logic [N-1:0] IRQ = '0;
    logic [3:0]   INT_MASK = '0;
    logic         INT_ACK = 1'b0;
    logic         INT_REQ;
    logic [3:0]   INT_LVL;
    logic [7:0]   INT_VEC;

    intc_prio_if ibus ();

    intc_prio #(.N_SRC(N), .BASE_ADDR(BASE), .NMI_VEC(8'd11)) dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .CE_R     (CE_R),
        .CE_F     (CE_F),
        .RES_N    (RES_N),
        .NMI_N    (NMI_N),
        .IRQ      (IRQ),
        .INT_MASK (INT_MASK),
        .INT_ACK  (INT_ACK),
        .INT_REQ  (INT_REQ),
        .INT_LVL  (INT_LVL),
        .INT_VEC  (INT_VEC),
        .ibus     (ibus)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference state: registers, pending flags and the presented request.
    logic [15:0]  m_src [N];
    logic [N-1:0] m_pend;
    logic [N-1:0] m_prev;
    logic         m_nmi;
    logic         m_nmi_prev;
    logic         m_req;
    logic [3:0]   m_lvl;
    logic [7:0]   m_vec;
    logic [31:0]  m_do;
    int           m_sel;

    logic [12:0]  exp_q [$];
    logic [31:0]  rd_q [$];
    logic [12:0]  mon_e;
    logic [31:0]  mon_d;

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_src[i] = 16'h0;
        m_pend = '0;
        m_prev = '0;
        m_nmi = 1'b0;
        m_nmi_prev = 1'b1;
        m_req = 1'b0;
        m_lvl = 4'hF;
        m_vec = 8'h0;
        m_do = 32'h0;
        m_sel = 0;
    endtask

    // One CE_R step of the model from the inputs currently driven.
    task automatic model_step();
        int win = -1;
        int wl = -1;
        int ct = -1;
        logic [31:0] off;
        logic [15:0] half;
        logic [1:0] be;
        int k;
        for (int i = 0; i < N; i++) begin
            if (m_pend[i] && m_src[i][11:8] > INT_MASK &&
                int'(m_src[i][11:8]) > wl) begin
                win = i;
                wl = int'(m_src[i][11:8]);
            end
        end
`ifdef INTC_PRIO_NMI_EN
        if (m_nmi) win = N;
`endif
        if (INT_ACK && m_req) begin
            ct = m_sel;
            m_req = 1'b0;
        end else begin
            m_req = (win >= 0);
            if (win >= 0) begin
                m_sel = win;
                if (win == N) begin
                    m_lvl = 4'hF;
                    m_vec = 8'd11;
                end else begin
                    m_lvl = m_src[win][11:8];
                    m_vec = {1'b0, m_src[win][6:0]};
                end
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!RES_N) m_pend[i] = 1'b0;
            else if (!m_src[i][15]) m_pend[i] = IRQ[i];
            else if (IRQ[i] && !m_prev[i]) m_pend[i] = 1'b1;
            else if (ct == i) m_pend[i] = 1'b0;
        end
`ifdef INTC_PRIO_NMI_EN
        if (!RES_N) m_nmi = 1'b0;
        else if (m_nmi_prev && !NMI_N) m_nmi = 1'b1;
        else if (ct == N) m_nmi = 1'b0;
`endif
        m_nmi_prev = NMI_N;
        m_prev = IRQ;
        off = ibus.IBUS_A - BASE;
        k = int'(off[5:1]);
        if (!RES_N) begin
            for (int i = 0; i < N; i++) m_src[i] = 16'h0;
        end else if (ibus.IBUS_REQ && ibus.IBUS_WE && off < 64 && k < N) begin
            half = ibus.IBUS_A[1] ? ibus.IBUS_DI[15:0] : ibus.IBUS_DI[31:16];
            be = ibus.IBUS_A[1] ? ibus.IBUS_BA[1:0] : ibus.IBUS_BA[3:2];
            if (be[1]) begin
                m_src[k][15:8] = half[15:8] & 8'h8F;
                m_pend[k] = 1'b0;
            end
            if (be[0]) m_src[k][7:0] = half[7:0] & 8'h7F;
        end
        exp_q.push_back({m_req, m_lvl, m_vec});
        if (ibus.IBUS_REQ && !ibus.IBUS_WE) begin
            if (off < 64) m_do = (k < N) ? {2{m_src[k]}} : 32'h0;
            rd_q.push_back(m_do);
        end
    endtask

    task automatic tick();
        model_step();
        CE_R = 1'b1;
        @(posedge CLK);
        #1 CE_R = 1'b0;
        CE_F = 1'b1;
        @(posedge CLK);
        #1 CE_F = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic bus(input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] be, input logic we);
        ibus.IBUS_A = a;
        ibus.IBUS_DI = d;
        ibus.IBUS_BA = be;
        ibus.IBUS_WE = we;
        ibus.IBUS_REQ = 1'b1;
        tick();
        ibus.IBUS_REQ = 1'b0;
        ibus.IBUS_WE = 1'b0;
    endtask

    task automatic wr_src(input int i, input logic [15:0] v);
        if (i % 2 == 1) bus(BASE + 32'(2 * i), {16'h0, v}, 4'b0011, 1'b1);
        else bus(BASE + 32'(2 * i), {v, 16'h0}, 4'b1100, 1'b1);
    endtask

    task automatic ack();
        INT_ACK = 1'b1;
        tick();
        INT_ACK = 1'b0;
    endtask

    always @(posedge CLK) begin
        if (RST_N && CE_R) begin
            @(negedge CLK);
            if (exp_q.size() == 0) begin
                check("int_q_underrun", 32'd1, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("int_out", {19'h0, INT_REQ, INT_LVL, INT_VEC},
                      {19'h0, mon_e});
            end
        end
    end

    always @(posedge CLK) begin
        if (RST_N && CE_F && ibus.IBUS_REQ && !ibus.IBUS_WE) begin
            @(negedge CLK);
            if (rd_q.size() == 0) begin
                check("rd_q_underrun", 32'd1, 32'd0);
            end else begin
                mon_d = rd_q.pop_front();
                check("ibus_do", ibus.IBUS_DO, mon_d);
            end
        end
    end

    initial begin
        ibus.IBUS_A = '0;
        ibus.IBUS_DI = '0;
        ibus.IBUS_BA = '0;
        ibus.IBUS_WE = 1'b0;
        ibus.IBUS_REQ = 1'b0;
        model_reset();
        repeat (3) @(posedge CLK);
        #1;
        check("rst_req", {31'h0, INT_REQ}, 32'h0);
        check("rst_lvl", {28'h0, INT_LVL}, 32'hF);
        check("rst_vec", {24'h0, INT_VEC}, 32'h0);
        check("rst_do", ibus.IBUS_DO, 32'h0);
        check("rst_busy", {31'h0, ibus.IBUS_BUSY}, 32'h0);
        RST_N = 1'b1;
        ticks(2);

        wr_src(3, 16'h0533);
        wr_src(7, 16'h0977);
        IRQ[3] = 1'b1;
        IRQ[7] = 1'b1;
        ticks(2);
        check("s1_req", {31'h0, INT_REQ}, 32'h1);
        check("s1_lvl", {28'h0, INT_LVL}, 32'h9);
        check("s1_vec", {24'h0, INT_VEC}, 32'h77);
        INT_ACK = 1'b1;
        IRQ[7] = 1'b0;
        tick();
        INT_ACK = 1'b0;
        check("s1_ack_gap", {31'h0, INT_REQ}, 32'h0);
        tick();
        check("s1_next_lvl", {28'h0, INT_LVL}, 32'h5);
        check("s1_next_vec", {24'h0, INT_VEC}, 32'h33);
        IRQ = '0;
        wr_src(3, 16'h0);
        wr_src(7, 16'h0);

        wr_src(2, 16'h8622);
        wr_src(4, 16'h8644);
        IRQ[2] = 1'b1;
        IRQ[4] = 1'b1;
        ticks(2);
        check("s2_tie_vec", {24'h0, INT_VEC}, 32'h22);
        ack();
        tick();
        check("s2_second_vec", {24'h0, INT_VEC}, 32'h44);
        ack();
        tick();
        check("s2_idle", {31'h0, INT_REQ}, 32'h0);
        IRQ = '0;
        wr_src(2, 16'h0);
        wr_src(4, 16'h0);

        wr_src(1, 16'h8311);
        IRQ[1] = 1'b1;
        ticks(2);
        ack();
        ticks(2);
        check("s3_held_high", {31'h0, INT_REQ}, 32'h0);
        IRQ[1] = 1'b0;
        tick();
        IRQ[1] = 1'b1;
        tick();
        tick();
        check("s3_rearm", {31'h0, INT_REQ}, 32'h1);
        ack();
        IRQ[1] = 1'b0;
        wr_src(1, 16'h0);

        INT_MASK = 4'd7;
        wr_src(0, 16'h0700);
        IRQ[0] = 1'b1;
        ticks(3);
        check("s4_masked", {31'h0, INT_REQ}, 32'h0);
        INT_MASK = 4'd6;
        tick();
        check("s4_unmasked", {31'h0, INT_REQ}, 32'h1);
        INT_MASK = 4'd0;
        IRQ[0] = 1'b0;
        wr_src(0, 16'h0);

        wr_src(5, 16'h0F55);
        IRQ[5] = 1'b1;
        ticks(2);
        NMI_N = 1'b0;
        ticks(2);
`ifdef INTC_PRIO_NMI_EN
        check("s5_nmi_lvl", {28'h0, INT_LVL}, 32'hF);
        check("s5_nmi_vec", {24'h0, INT_VEC}, 32'd11);
        ack();
        tick();
`endif
        check("s5_src5_vec", {24'h0, INT_VEC}, 32'h55);
        NMI_N = 1'b1;
        IRQ[5] = 1'b0;
        wr_src(5, 16'h0);

        wr_src(1, 16'h0311);
        bus(BASE + 32'd2, 32'h0000_8A00, 4'b0010, 1'b1);
        bus(BASE + 32'd2, 32'h0, 4'b0000, 1'b0);
        check("s6_byte_rd", ibus.IBUS_DO, 32'h8A11_8A11);
        bus(BASE + 32'd40, 32'h0, 4'b0000, 1'b0);
        check("s6_empty_rd", ibus.IBUS_DO, 32'h0);
        ibus.IBUS_A = BASE + 32'd62;
        #1 check("s6_act_in", {31'h0, ibus.IBUS_ACT}, 32'h1);
        ibus.IBUS_A = BASE + 32'd64;
        #1 check("s6_act_out", {31'h0, ibus.IBUS_ACT}, 32'h0);
        wr_src(1, 16'h0);

        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 2) == 0) IRQ = N'($urandom);
            if ($urandom_range(0, 7) == 0) INT_MASK = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 15) == 0) NMI_N = ~NMI_N;
            INT_ACK = m_req && ($urandom_range(0, 2) == 0);
            RES_N = ($urandom_range(0, 60) != 0);
            if ($urandom_range(0, 5) == 0) begin
                ibus.IBUS_A = BASE + 32'(2 * $urandom_range(0, N + 2));
                ibus.IBUS_DI = $urandom;
                ibus.IBUS_BA = 4'($urandom);
                ibus.IBUS_WE = 1'b1;
                ibus.IBUS_REQ = 1'b1;
            end else if ($urandom_range(0, 9) == 0) begin
                ibus.IBUS_A = BASE - 32'd8 + 32'(2 * $urandom_range(0, 40));
                ibus.IBUS_WE = 1'b0;
                ibus.IBUS_REQ = 1'b1;
            end
            tick();
            ibus.IBUS_REQ = 1'b0;
            ibus.IBUS_WE = 1'b0;
        end
        INT_ACK = 1'b0;
        RES_N = 1'b1;
        NMI_N = 1'b1;
        INT_MASK = 4'd0;
        IRQ = '0;
        IRQ[6] = 1'b1;
        wr_src(6, 16'h0E66);
        ticks(2);
        check("ar_pre_req", {31'h0, INT_REQ}, 32'h1);
        #3 RST_N = 1'b0;
        #1;
        check("ar_req", {31'h0, INT_REQ}, 32'h0);
        check("ar_lvl", {28'h0, INT_LVL}, 32'hF);
        check("ar_vec", {24'h0, INT_VEC}, 32'h0);
        check("ar_do", ibus.IBUS_DO, 32'h0);
        model_reset();
        @(posedge CLK);
        #1 RST_N = 1'b1;
        ticks(3);
        check("q_drain", 32'(exp_q.size() + rd_q.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
